// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: active-low hex glyphs and segment order.
// Glyph bits are {g,f,e,d,c,b,a}; a 0 lights the segment.
package seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef enum logic [2:0] {
        SEG_A = 3'd0,
        SEG_B = 3'd1,
        SEG_C = 3'd2,
        SEG_D = 3'd3,
        SEG_E = 3'd4,
        SEG_F = 3'd5,
        SEG_G = 3'd6
    } seg_idx_e;

    typedef logic [6:0] seg_t;

    localparam seg_t HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic seg_t hex_to_seg(input logic [3:0] nib);
        return HEX_SEG[nib];
    endfunction

    function automatic logic seg_lit(input seg_t s, input seg_idx_e i);
        return ~s[i];
    endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational 4-bit hex to active-low seven-segment glyph.
// Shared with the single-digit display paths.
module seven_seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seven_seg_mux.sv
// Time-multiplexed common-anode driver with dead time, blanking and
// frame-aligned double buffering of the displayed values.
module seven_seg_mux
    import seg_pkg::*;
#(
    parameter int NDIGITS     = 2,
    parameter int REFRESH_DIV = 24000,
    parameter int DEAD_CYCLES = 240
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4*NDIGITS-1:0]   digits,
    input  logic [NDIGITS-1:0]     dp_in,
    input  logic [NDIGITS-1:0]     blank,
    input  logic                   load,
    output logic [6:0]             seg,
    output logic                   dp,
    output logic [NDIGITS-1:0]     an,
    output logic                   frame_start
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] I_LAST = IW'(NDIGITS - 1);

    logic [PW-1:0] cnt;
    logic [IW-1:0] idx;

    logic [NDIGITS-1:0][3:0] pend_dig;
    logic [NDIGITS-1:0][3:0] act_dig;
    logic [NDIGITS-1:0][3:0] show_dig;
    logic [NDIGITS-1:0]      pend_dp;
    logic [NDIGITS-1:0]      pend_bl;
    logic [NDIGITS-1:0]      act_dp;
    logic [NDIGITS-1:0]      act_bl;
    logic [NDIGITS-1:0]      show_dp;
    logic [NDIGITS-1:0]      show_bl;
    logic                    pend_valid;

    logic               at_frame;
    logic               take;
    logic               dead_zone;
    logic               live;
    logic [NDIGITS-1:0] an_sel;
    logic [6:0]         dec_seg;

    generate
        if (DEAD_CYCLES == 0) begin : g_no_dead
            assign dead_zone = 1'b0;
        end else begin : g_dead
            assign dead_zone = (cnt < PW'(DEAD_CYCLES));
        end
    endgenerate

    // The slot-0 entry cycle already displays the freshly transferred
    // buffer, so the whole frame comes from one snapshot.
    always_comb begin
        at_frame = (cnt == '0) && (idx == '0);
        take     = at_frame && pend_valid;
        show_dig = take ? pend_dig : act_dig;
        show_dp  = take ? pend_dp : act_dp;
        show_bl  = take ? pend_bl : act_bl;
        an_sel   = '1;
        an_sel[idx] = 1'b0;
        live     = !dead_zone && !show_bl[idx];
    end

    seven_seg_decoder u_dec (
        .nibble (show_dig[idx]),
        .seg    (dec_seg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            idx         <= '0;
            pend_dig    <= '0;
            pend_dp     <= '0;
            pend_bl     <= '0;
            pend_valid  <= 1'b0;
            act_dig     <= '0;
            act_dp      <= '0;
            act_bl      <= '0;
            seg         <= SEG_OFF;
            dp          <= 1'b1;
            an          <= '1;
            frame_start <= 1'b0;
        end else begin
            if (cnt == P_LAST) begin
                cnt <= '0;
                idx <= (idx == I_LAST) ? '0 : idx + IW'(1);
            end else begin
                cnt <= cnt + PW'(1);
            end

            act_dig <= show_dig;
            act_dp  <= show_dp;
            act_bl  <= show_bl;
            if (take) begin
                pend_valid <= 1'b0;
            end
            // A load on the transfer cycle lands after the snapshot.
            if (load) begin
                pend_dig   <= digits;
                pend_dp    <= dp_in;
                pend_bl    <= blank;
                pend_valid <= 1'b1;
            end

            frame_start <= at_frame;
            an          <= live ? an_sel : '1;
            seg         <= live ? dec_seg : SEG_OFF;
            dp          <= live ? ~show_dp[idx] : 1'b1;
        end
    end

endmodule

// File: tb/tb_seven_seg_mux.sv
// Self-checking bench: two configurations against a cycle-count based
// reference model of the display frame.
module tb_seven_seg_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [7:0] dig_a = '0;
    logic [1:0] dpi_a = '0;
    logic [1:0] bl_a = '0;
    logic       ld_a = 1'b0;
    logic [6:0] seg_a;
    logic       dp_a;
    logic [1:0] an_a;
    logic       fs_a;

    logic [15:0] dig_b = '0;
    logic [3:0]  dpi_b = '0;
    logic [3:0]  bl_b = '0;
    logic        ld_b = 1'b0;
    logic [6:0]  seg_b;
    logic        dp_b;
    logic [3:0]  an_b;
    logic        fs_b;

    seven_seg_mux #(.NDIGITS(2), .REFRESH_DIV(8), .DEAD_CYCLES(2)) dut_a (
        .clk(clk), .reset(rst), .digits(dig_a), .dp_in(dpi_a),
        .blank(bl_a), .load(ld_a), .seg(seg_a), .dp(dp_a),
        .an(an_a), .frame_start(fs_a)
    );

    seven_seg_mux #(.NDIGITS(4), .REFRESH_DIV(4), .DEAD_CYCLES(0)) dut_b (
        .clk(clk), .reset(rst), .digits(dig_b), .dp_in(dpi_b),
        .blank(bl_b), .load(ld_b), .seg(seg_b), .dp(dp_b),
        .an(an_b), .frame_start(fs_b)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit started = 1'b0;

    bit [6:0] HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef struct packed {
        int n;
        int rd;
        int dc;
        int k;
        bit pv;
        bit [3:0][3:0] pd;
        bit [3:0][3:0] ad;
        bit [3:0] pdp;
        bit [3:0] adp;
        bit [3:0] pbl;
        bit [3:0] abl;
    } mdl_t;

    mdl_t ma;
    mdl_t mb;

    // k is the index of the output cycle the next clock edge produces.
    task automatic mstep(inout mdl_t m, input bit r, input bit ld,
                         input bit [15:0] dg, input bit [3:0] dpi,
                         input bit [3:0] bli, output bit [6:0] es,
                         output bit edp, output bit [3:0] ean,
                         output bit efs);
        int p;
        int s;
        bit lv;
        if (r) begin
            m.k = 0; m.pv = 0;
            m.pd = '0; m.ad = '0;
            m.pdp = '0; m.adp = '0; m.pbl = '0; m.abl = '0;
            es = 7'h7F; edp = 1'b1; ean = 4'hF; efs = 1'b0;
            return;
        end
        p = m.k % m.rd;
        s = (m.k / m.rd) % m.n;
        efs = (m.k % (m.n * m.rd)) == 0;
        if (efs && m.pv) begin
            m.ad = m.pd; m.adp = m.pdp; m.abl = m.pbl; m.pv = 0;
        end
        lv = (p >= m.dc) && !m.abl[s];
        es = lv ? HEX[m.ad[s]] : 7'h7F;
        edp = lv ? !m.adp[s] : 1'b1;
        ean = 4'hF;
        if (lv) ean[s] = 1'b0;
        if (ld) begin
            m.pd = dg; m.pdp = dpi; m.pbl = bli; m.pv = 1;
        end
        m.k++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit [6:0] es;
        bit edp;
        bit [3:0] ean;
        bit efs;
        @(posedge clk);
        #1;
        mstep(ma, rst, ld_a, {8'h0, dig_a}, {2'b0, dpi_a}, {2'b0, bl_a},
              es, edp, ean, efs);
        chk("a_seg", 32'(seg_a), 32'(es));
        chk("a_dp", 32'(dp_a), 32'(edp));
        chk("a_an", 32'({2'b11, an_a}), 32'(ean));
        chk("a_fs", 32'(fs_a), 32'(efs));
        mstep(mb, rst, ld_b, dig_b, dpi_b, bl_b, es, edp, ean, efs);
        chk("b_seg", 32'(seg_b), 32'(es));
        chk("b_dp", 32'(dp_b), 32'(edp));
        chk("b_an", 32'(an_b), 32'(ean));
        chk("b_fs", 32'(fs_b), 32'(efs));
        ld_a = 1'b0;
        ld_b = 1'b0;
    endtask

    task automatic run_to(input int ph);
        while ((ma.k % 16) != ph) step();
    endtask

    always @(negedge clk) begin
        if (started) begin
            n_cmp++;
            assert ($countones(~an_a) <= 1) else begin
                n_err++;
                $error("FAIL onehot_a an=%b expected at most one low", an_a);
            end
            n_cmp++;
            assert ($countones(~an_b) <= 1) else begin
                n_err++;
                $error("FAIL onehot_b an=%b expected at most one low", an_b);
            end
        end
    end

    initial begin
        ma = '0; ma.n = 2; ma.rd = 8; ma.dc = 2;
        mb = '0; mb.n = 4; mb.rd = 4; mb.dc = 0;

        rst = 1'b1;
        step(); step();
        started = 1'b1;
        chk("rst_seg", 32'(seg_a), 32'h7F);
        chk("rst_an", 32'(an_a), 32'h3);
        rst = 1'b0;

        // Cycle 0: B also queues a random frame for its next frame.
        dig_b = 16'($urandom);
        dpi_b = 4'($urandom);
        ld_b = 1'b1;
        for (int c = 0; c <= 16; c++) begin
            step();
            if (c == 0)  chk("fs_c0", 32'(fs_a), 32'h1);
            if (c == 1)  chk("an_dead1", 32'(an_a), 32'h3);
            if (c == 2)  chk("an_d0", 32'(an_a), 32'h2);
            if (c == 7)  chk("seg_0", 32'(seg_a), 32'h40);
            if (c == 8)  chk("an_dead8", 32'(an_a), 32'h3);
            if (c == 10) chk("an_d1", 32'(an_a), 32'h1);
            if (c == 16) chk("fs_c16", 32'(fs_a), 32'h1);
            if (c < 16)
                chk("b_walk", 32'(an_b), 32'(4'hF ^ (4'h1 << ((c / 4) % 4))));
        end

        // Mid-frame load only shows from the next frame.
        run_to(4);
        dig_a = 8'hA1; ld_a = 1'b1;
        step();
        run_to(10); step();
        chk("a1_old", 32'(seg_a), 32'h40);
        run_to(2); step();
        chk("a1_d0", 32'(seg_a), 32'h79);
        run_to(10); step();
        chk("a1_d1", 32'(seg_a), 32'h08);

        // Load exactly on the transfer cycle.
        dig_a = 8'hF8; ld_a = 1'b1;
        step();
        run_to(0);
        dig_a = 8'h3C; ld_a = 1'b1;
        step();
        run_to(2); step();
        chk("f8_d0", 32'(seg_a), 32'h00);
        run_to(10); step();
        chk("f8_d1", 32'(seg_a), 32'h0E);
        run_to(2); step();
        chk("3c_d0", 32'(seg_a), 32'h46);
        run_to(10); step();
        chk("3c_d1", 32'(seg_a), 32'h30);

        // Blank digit 1, decimal point on digit 0.
        dig_a = 8'h55; dpi_a = 2'b01; bl_a = 2'b10; ld_a = 1'b1;
        step();
        run_to(3); step();
        chk("dp_d0", 32'(dp_a), 32'h0);
        chk("an_d0b", 32'(an_a), 32'h2);
        run_to(12); step();
        chk("blank_d1", 32'(an_a), 32'h3);

        // Reset mid-frame discards pending.
        run_to(5);
        dig_a = 8'h77; dpi_a = 2'b00; bl_a = 2'b00; ld_a = 1'b1;
        step();
        run_to(11);
        rst = 1'b1;
        step();
        chk("mrst_seg", 32'(seg_a), 32'h7F);
        chk("mrst_an", 32'(an_a), 32'h3);
        rst = 1'b0;
        step();
        chk("mrst_fs", 32'(fs_a), 32'h1);
        run_to(2); step();
        chk("mrst_pend", 32'(seg_a), 32'h40);
        run_to(2); step();
        chk("mrst_pend2", 32'(seg_a), 32'h40);

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 150) == 0);
            ld_a = ($urandom_range(0, 12) == 0);
            dig_a = 8'($urandom);
            dpi_a = 2'($urandom);
            bl_a = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            ld_b = ($urandom_range(0, 9) == 0);
            dig_b = 16'($urandom);
            dpi_b = 4'($urandom);
            bl_b = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            step();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seven_seg_mux.md
# seven_seg_mux

Parametrised, time-multiplexed seven-segment display driver for the board's common-anode digit displays. It generalises the single-digit switch-to-segment path to NDIGITS digits sharing one segment bus. It adds a refresh prescaler, anti-ghosting dead time, per-digit blanking and decimal points, and frame-aligned double buffering. It sits between user logic, which presents hex nibbles plus a load strobe, and the top-level pins.

## Interface
- NDIGITS, 2: number of multiplexed digits, ≥1
- REFRESH_DIV, 24000: clock cycles per digit slot, ≥2
- DEAD_CYCLES, 240: cycles at the start of each slot with all anodes off, 0 ≤ DEAD_CYCLES < REFRESH_DIV

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- digits  in  4*NDIGITS  hex nibbles; digit i = digits[4i+3:4i]
- dp_in  in  NDIGITS  decimal point request per digit, 1 = lit
- blank  in  NDIGITS  1 = digit i dark for its whole slot
- load  in  1  single-cycle strobe; captures digits/dp_in/blank into pending buffer
- seg  out  7  active-low segments {g,f,e,d,c,b,a}
- dp  out  1  active-low decimal point
- an  out  NDIGITS  active-low anode enables, at most one low
- frame_start  out  1  one-cycle pulse on the first cycle of slot 0

## Operation
- Reset: seg=7'h7F, dp=1, an all 1, frame_start=0; prescaler, slot index, active and pending buffers all 0; pending_valid=0.
- Prescaler counts 0..REFRESH_DIV-1 and wraps; on wrap, slot index increments 0..NDIGITS-1 and wraps to 0.
- Prescaler position p < DEAD_CYCLES: an all 1, seg=7'h7F, dp=1.
- p ≥ DEAD_CYCLES: an[idx]=0, seg=decode(active nibble idx), dp=~active_dp[idx].
- active_blank[idx]=1: the whole slot behaves as dead time, while timing continues.
- Decode is active-low hex. Examples: 0→1000000, 1→1111001, 8→0000000, A→0001000, F→0001110.
- load: pending ← {digits, dp_in, blank}; pending_valid ← 1. A later load before transfer overwrites pending.
- Transfer: on the cycle entering slot 0 (prescaler wrap with idx=NDIGITS-1, or the first cycle after reset), if pending_valid, then active ← pending and pending_valid ← 0. A frame never mixes old and new values.
- load coincident with the transfer cycle: the transfer uses the previously held pending. The new load lands in pending, pending_valid stays 1, and it is shown from the next frame.
- NDIGITS=1: idx is constant 0 and the frame equals one slot.
- Index counter width is max(1,$clog2(NDIGITS)); prescaler width is $clog2(REFRESH_DIV).

## Timing
- All outputs are registered. Output cycle k after reset deassert reflects prescaler position k mod REFRESH_DIV.
- The first output cycle after reset is slot 0, p=0, and frame_start=1.
- Frame period is NDIGITS*REFRESH_DIV cycles. frame_start is high exactly once per frame.
- Load latency: the new value appears on seg at the first non-dead cycle of the next frame, no earlier.
- Reset asserted mid-frame: on the next clock all outputs return to reset values and pending is discarded.
- an is never low during dead cycles. No two an bits are low in the same cycle.

## Structure
- Package seg_pkg:
  - 16-entry active-low hex pattern constant
  - SEG_OFF = 7'h7F
  - segment-order typedef
- Sub-module seven_seg_decoder: combinational 4-bit → 7-bit active-low decode from seg_pkg. Reused by the single-digit designs.
- seven_seg_mux contains the prescaler, slot counter, pending/active buffers, and output registers.

## Test plan
(Unless noted: NDIGITS=2, REFRESH_DIV=8, DEAD_CYCLES=2.)
- Reset release, digits=8'h00 → frame_start at cycle 0; cycles 0–1 an=11; cycles 2–7 an=10, seg=1000000; cycles 8–9 an=11; cycles 10–15 an=01; frame_start again at cycle 16.
- load with digits=8'hA1 mid-frame → the current frame still shows 0/0; the next frame shows digit0 seg=1111001 and digit1 seg=0001000.
- load of 8'h3C on the exact transfer cycle after a pending 8'hF8 → the next frame shows F8, and the frame after shows 3C.
- blank=2'b10, dp_in=2'b01 → digit1 slot has an=11 throughout; digit0 slot has dp=0.
- reset asserted at cycle 11 → outputs at cycle 12 are seg=7F, an=11; the sequence restarts as after the first reset; pending is cleared.
- NDIGITS=4, REFRESH_DIV=4, DEAD_CYCLES=0 → an walks 1110, 1101, 1011, 0111 every 4 cycles; one-hot-low is checked by an assertion every cycle.
